mult_sequencer: RTL and testbench

Operand sequencer and result buffer sitting directly upstream of the 8-bit shift-add `multiply` block. It accepts operand pairs over a valid/ready handshake and drives `multiply`'s `ain`/`bin`/`reset` inputs. It watches `multiply`'s `ready`, captures the finished `prod`, and presents it downstream with a valid/ready handshake, a latency count and a timeout error flag. It brings the multiplier under transaction control, one multiplication in flight at a time.

---
 rtl/mult_sequencer.sv | 124 ++++++++++++
 tb/tb_mult_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Operand sequencer and result buffer for the 8-bit shift-add multiply block.
// One multiplication in flight; result held until the downstream handshake.
module mult_sequencer #(
  parameter int unsigned TIMEOUT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [7:0]  mul_ain,
  output logic [7:0]  mul_bin,
  output logic        mul_reset,
  input  logic [15:0] mul_prod,
  input  logic        mul_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic [3:0]  out_cycles,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  ain_d, bin_d;
  logic        mrst_d;
  logic        ov_d;
  logic [15:0] prod_d;
  logic [3:0]  cyc_d;
  logic        err_d;

  // Accept only in IDLE and never while reset is asserted.
  assign in_ready = (state_q == IDLE) && reset;

  // State, counter and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mul_ain    <= '0;
      mul_bin    <= '0;
      mul_reset  <= 1'b1;
      out_valid  <= 1'b0;
      out_prod   <= '0;
      out_cycles <= '0;
      out_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_ain    <= ain_d;
      mul_bin    <= bin_d;
      mul_reset  <= mrst_d;
      out_valid  <= ov_d;
      out_prod   <= prod_d;
      out_cycles <= cyc_d;
      out_err    <= err_d;
    end
  end

  // Next-state and next-output decode; everything holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ain_d   = mul_ain;
    bin_d   = mul_bin;
    mrst_d  = mul_reset;
    ov_d    = out_valid;
    prod_d  = out_prod;
    cyc_d   = out_cycles;
    err_d   = out_err;
    unique case (state_q)
      IDLE: begin
        mrst_d = 1'b0;
        if (in_valid && in_ready) begin
          ain_d   = in_a;
          bin_d   = in_b;
          mrst_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        // mul_ready still reflects the old B here
        mrst_d  = 1'b0;
        cnt_d   = 4'd1;
        state_d = RUN;
      end
      RUN: begin
        if (mul_ready) begin
          prod_d  = mul_prod;
          cyc_d   = cnt_q;
          err_d   = 1'b0;
          ov_d    = 1'b1;
          state_d = DONE;
        end else if (cnt_q == TMO) begin
          prod_d  = '0;
          cyc_d   = TMO;
          err_d   = 1'b1;
          ov_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural shift-add multiplier.
// Expected values are hand-computed constants.
module tb_mult_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a, in_b;
  logic [7:0]  mul_ain, mul_bin;
  logic        mul_reset;
  logic [15:0] mul_prod;
  logic        mul_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_prod;
  logic [3:0]  out_cycles;
  logic        out_err;

  int nvec = 0;
  int nerr = 0;

  // Multiplier model: load on reset, else shift-add; ready when B is empty.
  logic [15:0] ma, macc;
  logic [7:0]  mb;
  logic        stuck = 1'b0;

  always @(posedge clk) begin
    if (mul_reset) begin
      ma   <= {8'd0, mul_ain};
      mb   <= mul_bin;
      macc <= '0;
    end else begin
      if (mb[0]) macc <= macc + ma;
      ma <= ma << 1;
      mb <= mb >> 1;
    end
  end

  assign mul_prod  = macc;
  assign mul_ready = !stuck && (mb == 8'd0);

  mult_sequencer #(.TIMEOUT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .mul_ain    (mul_ain),
    .mul_bin    (mul_bin),
    .mul_reset  (mul_reset),
    .mul_prod   (mul_prod),
    .mul_ready  (mul_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_prod   (out_prod),
    .out_cycles (out_cycles),
    .out_err    (out_err)
  );

  always #30 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operand pair; return edges from accept to out_valid.
  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      output int edges);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = 8'hA5;
    in_b = 8'h5A;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1; edges++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drain_out_valid", 32'(out_valid), 32'd0);
    chk("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int e;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    #5 reset = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mul_reset", 32'(mul_reset), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_prod", 32'(out_prod), 32'd0);
    chk("rst_out_cycles", 32'(out_cycles), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_mul_ain", 32'(mul_ain), 32'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_mul_reset", 32'(mul_reset), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // out_ready in IDLE is ignored
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ignore_oready", 32'(in_ready), 32'd1);

    // 13 x 11, also check registered operands right after accept
    in_valid = 1'b1; in_a = 8'd13; in_b = 8'd11;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = 8'hFF; in_b = 8'hFF;
    chk("load_mul_ain", 32'(mul_ain), 32'd13);
    chk("load_mul_bin", 32'(mul_bin), 32'd11);
    chk("load_mul_reset", 32'(mul_reset), 32'd1);
    chk("load_in_ready", 32'(in_ready), 32'd0);
    e = 0;
    while (!out_valid && e < 40) begin
      @(posedge clk); #1; e++;
    end
    chk("13x11_latency", 32'(e), 32'd6);
    chk("13x11_prod", 32'(out_prod), 32'h008F);
    chk("13x11_cycles", 32'(out_cycles), 32'd5);
    chk("13x11_err", 32'(out_err), 32'd0);
    drain();

    send(8'd255, 8'd255, e);
    chk("255x255_prod", 32'(out_prod), 32'hFE01);
    chk("255x255_cycles", 32'(out_cycles), 32'd9);
    chk("255x255_latency", 32'(e), 32'd10);
    drain();

    send(8'd1, 8'd128, e);
    chk("1x128_prod", 32'(out_prod), 32'h0080);
    chk("1x128_cycles", 32'(out_cycles), 32'd9);
    drain();

    send(8'd200, 8'd0, e);
    chk("200x0_prod", 32'(out_prod), 32'h0000);
    chk("200x0_cycles", 32'(out_cycles), 32'd1);
    chk("200x0_latency", 32'(e), 32'd2);
    drain();

    send(8'd0, 8'd77, e);
    chk("0x77_prod", 32'(out_prod), 32'h0000);
    chk("0x77_cycles", 32'(out_cycles), 32'd8);
    drain();

    // backpressure
    send(8'd6, 8'd7, e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_prod", 32'(out_prod), 32'd42);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    chk("bp_cycles", 32'(out_cycles), 32'd4);
    drain();

    // reset in the 3rd RUN cycle
    in_valid = 1'b1; in_a = 8'd7; in_b = 8'd128;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #4 reset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_mul_reset", 32'(mul_reset), 32'd1);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_mul_bin", 32'(mul_bin), 32'd0);
    @(posedge clk); #1;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    chk("postrst_valid", 32'(out_valid), 32'd0);
    send(8'd3, 8'd5, e);
    chk("3x5_prod", 32'(out_prod), 32'd15);
    chk("3x5_cycles", 32'(out_cycles), 32'd4);
    drain();

    // timeout
    stuck = 1'b1;
    send(8'd9, 8'd9, e);
    chk("tmo_latency", 32'(e), 32'd11);
    chk("tmo_valid", 32'(out_valid), 32'd1);
    chk("tmo_err", 32'(out_err), 32'd1);
    chk("tmo_prod", 32'(out_prod), 32'd0);
    chk("tmo_cycles", 32'(out_cycles), 32'd10);
    stuck = 1'b0;
    drain();

    // clean result after an error clears the flag
    send(8'd2, 8'd3, e);
    chk("2x3_prod", 32'(out_prod), 32'd6);
    chk("2x3_cycles", 32'(out_cycles), 32'd3);
    chk("2x3_err", 32'(out_err), 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
